// File: rtl/scan_ctrl.sv
// -----------------------------------------------------------------------------
// scan_ctrl
//   Initiator side of a scan-chain interface. For each accepted request it
//   shifts a pattern word into an attached chain of N scan flops (MSB first),
//   runs one functional capture cycle, then shifts the captured word back out
//   into a parallel response register and pulses done.
//
// Parameters
//   N        number of flops in the attached scan chain (2..256)
//   CW       bit-counter width, derived from N
//
// Ports
//   clk      system clock, rising-edge active
//   rst      asynchronous active-low reset
//   start    request a scan test (only sampled while idle)
//   pattern  stimulus word, latched when start is accepted
//   scan_out serial output of the last chain stage (N-1)
//   mode     to every chain flop: 1 = shift, 0 = functional capture
//   scan_in  serial data into chain stage 0
//   busy     high from the cycle after acceptance through the done cycle
//   done     one-cycle pulse; response valid in that cycle and afterwards
//   response captured chain contents, bit k = chain stage k after capture
// -----------------------------------------------------------------------------
module scan_ctrl #(
    parameter  int unsigned N  = 8,
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] pattern,
    input  logic         scan_out,
    output logic         mode,
    output logic         scan_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] response
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        CAPTURE,
        SHIFT_OUT,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] rev_idx;
    logic [N-1:0]  pattern_q;
    logic          cnt_last;

    assign cnt_last = (cnt == CW'(N - 1));

    // Both shift phases walk the word MSB first, so the active bit position
    // is the counter mirrored about N-1.
    assign rev_idx  = CW'(N - 1) - cnt;

    // State, counter and data registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            pattern_q <= '0;
            response  <= '0;
        end else begin
            state <= state_nxt;

            // Counter restarts on every state change so it never exceeds N-1.
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (state == SHIFT_IN || state == SHIFT_OUT) begin
                cnt <= cnt + 1'b1;
            end

            if (state == IDLE && start) begin
                pattern_q <= pattern;
            end

            // Chain stage N-1-j appears on scan_out during shift-out cycle j.
            if (state == SHIFT_OUT) begin
                response[rev_idx] <= scan_out;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start)    state_nxt = SHIFT_IN;
            SHIFT_IN:  if (cnt_last) state_nxt = CAPTURE;
            CAPTURE:                 state_nxt = SHIFT_OUT;
            SHIFT_OUT: if (cnt_last) state_nxt = DONE;
            DONE:                    state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from registered state/counter only
    always_comb begin
        mode    = 1'b0;
        scan_in = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state)
            IDLE:      busy = 1'b0;
            SHIFT_IN: begin
                mode    = 1'b1;
                scan_in = pattern_q[rev_idx];
            end
            CAPTURE:   mode = 1'b0;
            SHIFT_OUT: mode = 1'b1;
            DONE:      done = 1'b1;
            default:   busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scan_ctrl
//   Self-checking bench for scan_ctrl. An N=8 and an N=2 instance each drive a
//   behavioural scan chain whose functional d inputs are either a constant or
//   the flop's own q. Full tests come from a vector table; the multi-cycle
//   corner cases (ignored start, held start, reset mid-shift, N=2) are
//   hand-written sequences.
// -----------------------------------------------------------------------------
module tb_scan_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    // N = 8 instance and its chain
    logic       start8   = 1'b0;
    logic [7:0] pattern8 = '0;
    logic       scan_out8;
    logic       mode8, scan_in8, busy8, done8;
    logic [7:0] response8;
    logic [7:0] chain8   = '0;
    logic [7:0] d8_const = '0;
    logic       hold8    = 1'b0;

    scan_ctrl #(.N(8)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .start    (start8),
        .pattern  (pattern8),
        .scan_out (scan_out8),
        .mode     (mode8),
        .scan_in  (scan_in8),
        .busy     (busy8),
        .done     (done8),
        .response (response8)
    );

    always @(posedge clk) begin
        if (mode8) chain8 <= {chain8[6:0], scan_in8};
        else       chain8 <= hold8 ? chain8 : d8_const;
    end
    assign scan_out8 = chain8[7];

    // N = 2 instance, d inputs tied to 2'b10
    logic       start2   = 1'b0;
    logic [1:0] pattern2 = '0;
    logic       scan_out2;
    logic       mode2, scan_in2, busy2, done2;
    logic [1:0] response2;
    logic [1:0] chain2   = '0;

    scan_ctrl #(.N(2)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .start    (start2),
        .pattern  (pattern2),
        .scan_out (scan_out2),
        .mode     (mode2),
        .scan_in  (scan_in2),
        .busy     (busy2),
        .done     (done2),
        .response (response2)
    );

    always @(posedge clk) begin
        if (mode2) chain2 <= {chain2[0], scan_in2};
        else       chain2 <= 2'b10;
    end
    assign scan_out2 = chain2[1];

    // Bookkeeping
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] pat;
        logic       hold;
        logic [7:0] dconst;
        logic [7:0] exp_scan;
        logic [7:0] exp_resp;
    } vec_t;

    vec_t vecs[5];

    // One complete test on the N=8 instance; called with the DUT idle and
    // one tick after the previous edge.
    task automatic run_vec(input vec_t v, input string tag);
        logic [7:0]  sw;
        int unsigned caps, busyc, donec, done_at, shifts;
        hold8    = v.hold;
        d8_const = v.dconst;
        pattern8 = v.pat;
        start8   = 1'b1;
        tick();
        start8   = 1'b0;
        sw = '0; caps = 0; busyc = 0; donec = 0; done_at = 999; shifts = 0;
        for (int c = 0; c < 40; c++) begin
            if (c < 8) begin
                sw = {sw[6:0], scan_in8};
                if (mode8) shifts++;
            end
            if (busy8) busyc++;
            if (busy8 && !mode8 && !done8) caps++;
            if (done8) begin
                donec++;
                if (done_at == 999) begin
                    done_at = c;
                    chk($sformatf("%s resp_at_done", tag), 32'(response8), 32'(v.exp_resp));
                end
            end
            tick();
        end
        chk($sformatf("%s scan_word", tag),  32'(sw), 32'(v.exp_scan));
        chk($sformatf("%s shift_mode", tag), shifts, 8);
        chk($sformatf("%s capture_cycles", tag), caps, 1);
        chk($sformatf("%s done_cycle", tag), done_at, 17);
        chk($sformatf("%s done_count", tag), donec, 1);
        chk($sformatf("%s busy_cycles", tag), busyc, 18);
        chk($sformatf("%s resp_held", tag), 32'(response8), 32'(v.exp_resp));
    endtask

    initial begin
        int unsigned donec, done_at, d1, d2, qc;
        logic [7:0]  r1, r2;
        logic [1:0]  sw2;

        //                pat    hold  dconst exp_scan exp_resp
        vecs[0] = '{8'hA5, 1'b0, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{8'h96, 1'b1, 8'h00, 8'h96, 8'h96};
        vecs[2] = '{8'h5A, 1'b0, 8'h00, 8'h5A, 8'h00};
        vecs[3] = '{8'h3C, 1'b0, 8'hFF, 8'h3C, 8'hFF};
        vecs[4] = '{8'h0F, 1'b1, 8'h00, 8'h0F, 8'h0F};

        // Reset state
        tick();
        tick();
        chk("rst mode",     32'(mode8),     0);
        chk("rst scan_in",  32'(scan_in8),  0);
        chk("rst busy",     32'(busy8),     0);
        chk("rst done",     32'(done8),     0);
        chk("rst response", 32'(response8), 0);
        chk("rst busy_n2",  32'(busy2),     0);
        rst = 1'b1;
        tick();

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Second start during SHIFT_OUT and pattern changes while busy are ignored
        hold8 = 1'b1; pattern8 = 8'h96; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        donec = 0; done_at = 999;
        for (int c = 0; c < 45; c++) begin
            if (c == 2)  pattern8 = 8'h00;
            if (c == 11) begin pattern8 = 8'hFF; start8 = 1'b1; end
            if (c == 12) start8 = 1'b0;
            if (done8) begin donec++; if (done_at == 999) done_at = c; end
            tick();
        end
        chk("ignore done_cycle", done_at, 17);
        chk("ignore done_count", donec, 1);
        chk("ignore response",   32'(response8), 32'h96);

        // start held high: one idle cycle between back-to-back tests
        hold8 = 1'b1; pattern8 = 8'h01; start8 = 1'b1;
        tick();
        pattern8 = 8'h80;
        donec = 0; d1 = 999; d2 = 999; r1 = '0; r2 = '0;
        for (int c = 0; c < 50; c++) begin
            if (c == 18) chk("held idle_gap", 32'(busy8), 0);
            if (c == 20) start8 = 1'b0;
            if (done8) begin
                donec++;
                if (donec == 1) begin d1 = c; r1 = response8; end
                if (donec == 2) begin d2 = c; r2 = response8; end
            end
            tick();
        end
        chk("held done_count", donec, 2);
        chk("held first_done", d1, 17);
        chk("held spacing",    d2 - d1, 19);
        chk("held resp1",      32'(r1), 32'h01);
        chk("held resp2",      32'(r2), 32'h80);

        // Reset asserted at SHIFT_IN j=3, released two cycles later
        hold8 = 1'b0; d8_const = 8'h3C; pattern8 = 8'hFF; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        chk("pre_rst scan_in", 32'(scan_in8), 1);
        rst = 1'b0;
        #1;
        chk("mid_rst mode",     32'(mode8),     0);
        chk("mid_rst scan_in",  32'(scan_in8),  0);
        chk("mid_rst busy",     32'(busy8),     0);
        chk("mid_rst response", 32'(response8), 0);
        tick();
        tick();
        rst = 1'b1;
        qc = 0;
        for (int c = 0; c < 25; c++) begin
            if (done8 || busy8) qc++;
            tick();
        end
        chk("post_rst quiet", qc, 0);
        run_vec(vecs[0], "after_rst");

        // N = 2 instance
        pattern2 = 2'b01; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        sw2 = '0; done_at = 999; donec = 0;
        for (int c = 0; c < 12; c++) begin
            if (c < 2) sw2 = {sw2[0], scan_in2};
            if (done2) begin donec++; if (done_at == 999) done_at = c; end
            tick();
        end
        chk("n2 scan_word",  32'(sw2), 32'h1);
        chk("n2 done_cycle", done_at, 5);
        chk("n2 done_count", donec, 1);
        chk("n2 response",   32'(response2), 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected completion before 200000");
        $fatal(1);
    end

endmodule

// File: doc/scan_ctrl.md
Name: scan_ctrl

Overview:
- Scan-chain test controller: the initiator side of the scan interface, driving `mode` and `scan_in` into a chain of N `scan_dff` cells and collecting the chain's serial `scan_out`.
- Per request it shifts a pattern word into the chain, runs one functional capture cycle, then shifts the captured response out into a parallel register.
- It sits between a test sequencer (start/done handshake) and the scan chain of the logic under test.

Parameters:
- N, 8, number of flops in the attached scan chain; legal range 2..256.
- CW, $clog2(N), width of the internal bit counter; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a scan test; sampled only in IDLE.
- pattern  input  N  stimulus word; latched on start acceptance.
- scan_out  input  1  serial output of the last chain flop (stage N-1).
- mode  output  1  to every chain flop: 1 = shift, 0 = functional capture.
- scan_in  output  1  serial data into chain stage 0.
- busy  output  1  high from the cycle after start acceptance until DONE ends.
- done  output  1  single-cycle pulse; response is valid in that cycle and afterwards.
- response  output  N  captured chain contents; bit k = value of chain stage k after capture.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, latched pattern=0, response=0.
  - Outputs in reset: mode=0, scan_in=0, busy=0, done=0.
  - Reset mid-operation abandons the test immediately; no done pulse.
- Chain convention: stage 0 is fed by scan_in; stage N-1 drives scan_out. During shift each stage loads its predecessor on the clock edge.
- IDLE: mode=0, scan_in=0, busy=0.
  - If start=1 at a rising edge: latch pattern, counter=0, go to SHIFT_IN.
- SHIFT_IN, N cycles, counter j=0..N-1: mode=1, scan_in=pattern_q[N-1-j], busy=1.
  - After the N-th edge, chain stage k holds pattern[k]; go to CAPTURE.
- CAPTURE, 1 cycle: mode=0, scan_in=0, busy=1.
  - Chain loads its functional d inputs on the edge; counter=0; go to SHIFT_OUT.
- SHIFT_OUT, N cycles, j=0..N-1: mode=1, scan_in=0, busy=1.
  - On each edge, response[N-1-j] <= scan_out.
  - After the N-th edge, response holds the full captured word; go to DONE.
- DONE, 1 cycle: done=1, busy=1, mode=0, scan_in=0; next state IDLE.
- Output timing: mode, scan_in, busy and done are decoded from registered state/counter only. No combinational path from start or scan_out to any output.
- Latency: start accepted at edge E0 → done high in the cycle after edge E0+2N+1. Total occupancy is 2N+2 cycles, after which the controller is back in IDLE.
- Ignored inputs:
  - start while not in IDLE: ignored; pattern changes while busy are ignored.
  - start held high continuously: a new test is accepted on the first edge spent in IDLE, i.e. one idle cycle between tests.
- response is held from DONE until the first SHIFT_OUT edge of the next test. Its bits are written progressively during that test's SHIFT_OUT.
- Counter wrap: the counter resets to 0 on every state transition and never exceeds N-1.

Test Plan:
- N=8, chain of scan_dff with d inputs tied to 8'h3C; pattern=8'hA5, start pulsed:
  - scan_in over SHIFT_IN = 1,0,1,0,0,1,0,1;
  - mode=0 for exactly one cycle;
  - done pulses 18 cycles after acceptance;
  - response=8'h3C.
- Same chain with each d tied to its own q (hold); pattern=8'h96 → response=8'h96, busy high for 18 cycles.
- Second start pulse with pattern=8'hFF during SHIFT_OUT → ignored: no restart, response unchanged from the first test, exactly one done pulse.
- start held high, patterns 8'h01 then 8'h80 (d tied to q) → two done pulses 19 cycles apart; response=8'h01 then 8'h80.
- rst driven low at SHIFT_IN j=3, released 2 cycles later → outputs immediately mode=0, scan_in=0, busy=0, response=0; no done; next start runs a full, correct test.
- N=2 instance, d tied to 2'b10, pattern=2'b01 → scan_in sequence 0,1; done 6 cycles after acceptance; response=2'b10.
